// File: rtl/seq_eval_pkg.sv
// Shared types and constants for the sequence-detector evaluation controller.
package seq_eval_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_DUT,
        DRIVE,
        DRAIN,
        DONE
    } seq_eval_state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Fibonacci step: shift left, feedback from bits 15, 13, 12, 10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/seq_eval_lfsr.sv
// 16-bit Fibonacci LFSR stimulus source; load has priority over enable, one step per enabled cycle.
// Exposes only the MSB, which is the next stimulus bit; no backpressure.
module seq_eval_lfsr
    import seq_eval_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        msb
);

    logic [15:0] state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            state <= load_val;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

    assign msb = state[15];

endmodule

// File: rtl/seq_eval_controller.sv
// Resets a detector DUT, drives an LFSR stream into it and scores it against a golden detector;
// start-to-done is RST_CYCLES+STREAM_LEN+2 cycles, no backpressure. SEQ_EVAL_OVERLAP_EN selects overlapping golden detection.
module seq_eval_controller
    import seq_eval_pkg::*;
#(
    parameter logic [7:0] PATTERN     = 8'b0000_1101,
    parameter int         PATTERN_LEN = 4,
    parameter int         STREAM_LEN  = 64,
    parameter int         RST_CYCLES  = 2,
    parameter int         CW          = $clog2(STREAM_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   seed,
    output logic          dut_rst,
    output logic          dut_i,
    input  logic          dut_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_count,
    output logic [CW-1:0] mismatch_count,
    output logic [CW-1:0] first_fail
);

    localparam int             RCW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  STREAM_END = CW'(STREAM_LEN);
    localparam logic [8:0]     PMASK_W    = (9'd1 << PATTERN_LEN) - 9'd1;
    localparam logic [7:0]     PMASK      = PMASK_W[7:0];

    seq_eval_state_t state;
    logic [RCW-1:0]  rst_cnt;
    logic [CW-1:0]   drv_idx;
    logic [6:0]      hist;
    logic            exp_bit;
    logic            exp_vld;

    logic            start_acc;
    logic            lfsr_en;
    logic [15:0]     lfsr_seed;
    logic            lfsr_msb;
    logic [7:0]      hist_shift;
    logic            gold_hit;
    logic [6:0]      hist_next;
    logic            do_cmp;
    logic [CW-1:0]   cmp_idx;

    seq_eval_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val (lfsr_seed),
        .en       (lfsr_en),
        .msb      (lfsr_msb)
    );

    always_comb begin
        start_acc = (state == IDLE) && start && !abort;
        lfsr_seed = (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        lfsr_en   = 1'b0;
        if (!abort) begin
            if ((state == RESET_DUT) && (rst_cnt == RST_LAST)) begin
                lfsr_en = 1'b1;
            end
            if ((state == DRIVE) && (drv_idx != STREAM_END)) begin
                lfsr_en = 1'b1;
            end
        end
    end

    // Golden detector sees dut_i on the same edge the DUT samples it.
    always_comb begin
        hist_shift = {hist, dut_i};
        gold_hit   = ((hist_shift ^ PATTERN) & PMASK) == 8'h00;
`ifdef SEQ_EVAL_OVERLAP_EN
        hist_next  = hist_shift[6:0];
`else
        hist_next  = gold_hit ? 7'h00 : hist_shift[6:0];
`endif
    end

    // Compare slot: expected bit was registered one cycle earlier; abort edges never score.
    always_comb begin
        do_cmp  = !abort && exp_vld && ((state == DRIVE) || (state == DRAIN));
        cmp_idx = match_count + mismatch_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dut_rst <= 1'b1;
            dut_i   <= 1'b0;
            rst_cnt <= '0;
            drv_idx <= '0;
            hist    <= '0;
            exp_bit <= 1'b0;
            exp_vld <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state   <= RESET_DUT;
                        busy    <= 1'b1;
                        rst_cnt <= '0;
                        drv_idx <= '0;
                        hist    <= '0;
                        exp_vld <= 1'b0;
                    end
                end
                RESET_DUT: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        dut_rst <= 1'b1;
                        dut_i   <= 1'b0;
                    end else if (rst_cnt == RST_LAST) begin
                        state   <= DRIVE;
                        dut_rst <= 1'b0;
                        dut_i   <= lfsr_msb;
                        drv_idx <= CW'(1);
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        dut_rst <= 1'b1;
                        dut_i   <= 1'b0;
                        exp_vld <= 1'b0;
                    end else begin
                        hist    <= hist_next;
                        exp_bit <= gold_hit;
                        exp_vld <= 1'b1;
                        if (drv_idx == STREAM_END) begin
                            state <= DRAIN;
                            dut_i <= 1'b0;
                        end else begin
                            dut_i   <= lfsr_msb;
                            drv_idx <= drv_idx + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    exp_vld <= 1'b0;
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        dut_rst <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    dut_rst <= 1'b1;
                    dut_i   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    dut_rst <= 1'b1;
                    dut_i   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count    <= '0;
            mismatch_count <= '0;
            first_fail     <= '1;
        end else if (start_acc) begin
            match_count    <= '0;
            mismatch_count <= '0;
            first_fail     <= '1;
        end else if (do_cmp) begin
            if (dut_out == exp_bit) begin
                match_count <= match_count + CW'(1);
            end else begin
                mismatch_count <= mismatch_count + CW'(1);
                if (first_fail == '1) begin
                    first_fail <= cmp_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_eval_controller.sv
// Randomized self-checking bench for seq_eval_controller with a behavioural detector model and DUT stub.
module tb_seq_eval_controller;

    localparam int            SL   = 64;
    localparam int            CW   = 7;
    localparam int            L    = 4;
    localparam logic [7:0]    PAT  = 8'b0000_1101;
    localparam logic [CW-1:0] NONE = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   seed = 16'h0;
    logic          dut_rst;
    logic          dut_i;
    logic          dut_out = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_count;
    logic [CW-1:0] mismatch_count;
    logic [CW-1:0] first_fail;

    int n_cmp = 0;
    int n_fail = 0;

    int            mode = 0;
    int            rx_n = 0;
    logic [SL-1:0] rx_bits = '0;
    logic [SL-1:0] tx_bits = '0;

    seq_eval_controller #(
        .PATTERN     (PAT),
        .PATTERN_LEN (L),
        .STREAM_LEN  (SL),
        .RST_CYCLES  (2),
        .CW          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .seed           (seed),
        .dut_rst        (dut_rst),
        .dut_i          (dut_i),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .match_count    (match_count),
        .mismatch_count (mismatch_count),
        .first_fail     (first_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [SL-1:0] gen_stream(input logic [15:0] s0);
        logic [15:0]   s;
        logic [SL-1:0] b;
        s = s0;
        b = '0;
        for (int k = 0; k < SL; k++) begin
            b[k] = s[15];
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return b;
    endfunction

    // Pattern window ending at bit k; without overlap a hit needs L fresh bits since the last hit.
    function automatic logic [SL-1:0] build_exp(input logic [SL-1:0] s);
        logic [SL-1:0] e;
        int            last;
        logic          hit;
        e = '0;
        last = -SL;
        for (int k = 0; k < SL; k++) begin
            hit = (k >= L - 1);
            if (hit) begin
                for (int j = 0; j < L; j++) begin
                    if (s[k-j] !== PAT[j]) hit = 1'b0;
                end
            end
`ifndef SEQ_EVAL_OVERLAP_EN
            if (hit && (k - last) < L) hit = 1'b0;
`endif
            if (hit) last = k;
            e[k] = hit;
        end
        return e;
    endfunction

    function automatic int count_diff(input logic [SL-1:0] a, input logic [SL-1:0] b, input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (a[k] !== b[k]) c++;
        return c;
    endfunction

    function automatic logic [CW-1:0] first_diff(input logic [SL-1:0] a, input logic [SL-1:0] b, input int n);
        for (int k = 0; k < n; k++) if (a[k] !== b[k]) return CW'(k);
        return NONE;
    endfunction

    // Stand-in detector: registers its response on the edge that samples dut_i.
    always @(posedge clk) begin : stub
        logic          o;
        logic [SL-1:0] e;
        if (dut_rst) begin
            rx_n = 0;
            dut_out <= 1'b0;
        end else begin
            o = 1'b0;
            if (rx_n < SL) begin
                rx_bits[rx_n] = dut_i;
                e = build_exp(rx_bits);
                case (mode)
                    0:       o = e[rx_n];
                    1:       o = 1'b0;
                    2:       o = 1'b1;
                    default: o = 1'($urandom_range(1, 0));
                endcase
                tx_bits[rx_n] = o;
            end
            rx_n++;
            dut_out <= o;
        end
    end

    task automatic start_eval(input logic [15:0] s, input int m);
        @(negedge clk);
        mode  = m;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 1;
        seen = done;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (dut_rst !== 1'b1) begin n_fail++; $display("FAIL reset_dut_rst: got %b want 1", dut_rst); end
        n_cmp++; if (dut_i !== 1'b0) begin n_fail++; $display("FAIL reset_dut_i: got %b want 0", dut_i); end
        n_cmp++; if (match_count !== '0) begin n_fail++; $display("FAIL reset_match: got %0d want 0", match_count); end
        n_cmp++; if (mismatch_count !== '0) begin n_fail++; $display("FAIL reset_mismatch: got %0d want 0", mismatch_count); end
        n_cmp++; if (first_fail !== NONE) begin n_fail++; $display("FAIL reset_first_fail: got %0d want %0d", first_fail, NONE); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || dut_rst !== 1'b1) begin n_fail++; $display("FAIL idle_hold: got busy=%b dut_rst=%b want 0/1", busy, dut_rst); end
    endtask

    task automatic test_loopback();
        int cyc;
        bit seen;
        start_eval(16'h1234, 0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy: got %b want 1", busy); end
        wait_done(cyc, seen);
        n_cmp++; if (!seen || cyc != 68) begin n_fail++; $display("FAIL loop_latency: got %0d (seen=%0d) want 68", cyc, seen); end
        n_cmp++; if (match_count !== CW'(64)) begin n_fail++; $display("FAIL loop_match: got %0d want 64", match_count); end
        n_cmp++; if (mismatch_count !== '0) begin n_fail++; $display("FAIL loop_mismatch: got %0d want 0", mismatch_count); end
        n_cmp++; if (first_fail !== NONE) begin n_fail++; $display("FAIL loop_first_fail: got %0d want %0d", first_fail, NONE); end
        n_cmp++; if (rx_bits !== gen_stream(16'h1234)) begin n_fail++; $display("FAIL loop_stream: got %h want %h", rx_bits, gen_stream(16'h1234)); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL loop_after: got done=%b busy=%b want 0/0", done, busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (match_count !== CW'(64)) begin n_fail++; $display("FAIL loop_hold: got %0d want 64", match_count); end
    endtask

    task automatic test_tie_low();
        int            cyc;
        bit            seen;
        logic [SL-1:0] e;
        e = build_exp(gen_stream(16'h1234));
        start_eval(16'h1234, 1);
        wait_done(cyc, seen);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL tie0_done: got timeout after %0d want done", cyc); end
        n_cmp++; if (mismatch_count !== CW'(count_diff(e, '0, SL))) begin n_fail++; $display("FAIL tie0_mismatch: got %0d want %0d", mismatch_count, count_diff(e, '0, SL)); end
        n_cmp++; if (first_fail !== first_diff(e, '0, SL)) begin n_fail++; $display("FAIL tie0_first_fail: got %0d want %0d", first_fail, first_diff(e, '0, SL)); end
    endtask

    task automatic test_tie_high();
        int            cyc;
        bit            seen;
        logic [SL-1:0] e;
        e = build_exp(gen_stream(16'h1234));
        start_eval(16'h1234, 2);
        wait_done(cyc, seen);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL tie1_done: got timeout after %0d want done", cyc); end
        n_cmp++; if (mismatch_count !== CW'(count_diff(e, '1, SL))) begin n_fail++; $display("FAIL tie1_mismatch: got %0d want %0d", mismatch_count, count_diff(e, '1, SL)); end
        n_cmp++; if (first_fail !== first_diff(e, '1, SL)) begin n_fail++; $display("FAIL tie1_first_fail: got %0d want %0d", first_fail, first_diff(e, '1, SL)); end
    endtask

    task automatic test_seed_zero();
        int cyc;
        bit seen;
        start_eval(16'h0000, 0);
        wait_done(cyc, seen);
        n_cmp++; if (rx_bits !== gen_stream(16'hACE1)) begin n_fail++; $display("FAIL seed0_stream: got %h want %h", rx_bits, gen_stream(16'hACE1)); end
        n_cmp++; if (!seen || match_count !== CW'(64)) begin n_fail++; $display("FAIL seed0_match: got %0d (seen=%0d) want 64", match_count, seen); end
    endtask

    task automatic test_back_to_back();
        int            cyc;
        bit            seen;
        logic [15:0]   s;
        logic [SL-1:0] e;
        for (int it = 0; it < 4; it++) begin
            s = 16'($urandom_range(65535, 1));
            e = build_exp(gen_stream(s));
            start_eval(s, 3);
            wait_done(cyc, seen);
            n_cmp++; if (!seen || cyc != 68) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want 68", it, cyc); end
            n_cmp++; if (mismatch_count !== CW'(count_diff(e, tx_bits, SL))) begin n_fail++; $display("FAIL b2b_mismatch[%0d]: got %0d want %0d", it, mismatch_count, count_diff(e, tx_bits, SL)); end
            n_cmp++; if (match_count !== CW'(SL - count_diff(e, tx_bits, SL))) begin n_fail++; $display("FAIL b2b_match[%0d]: got %0d want %0d", it, match_count, SL - count_diff(e, tx_bits, SL)); end
            n_cmp++; if (first_fail !== first_diff(e, tx_bits, SL)) begin n_fail++; $display("FAIL b2b_first_fail[%0d]: got %0d want %0d", it, first_fail, first_diff(e, tx_bits, SL)); end
        end
    endtask

    task automatic test_abort();
        int            cnt;
        bit            saw_done;
        logic [15:0]   s;
        logic [SL-1:0] e;
        s = 16'($urandom_range(65535, 1));
        e = build_exp(gen_stream(s));
        start_eval(s, 3);
        cnt = 0;
        while ((int'(match_count) + int'(mismatch_count)) != 10 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++; if (cnt >= 200) begin n_fail++; $display("FAIL abort_reach: got timeout want 10 compares"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (dut_rst !== 1'b1) begin n_fail++; $display("FAIL abort_dut_rst: got %b want 1", dut_rst); end
        n_cmp++; if (mismatch_count !== CW'(count_diff(e, tx_bits, 10))) begin n_fail++; $display("FAIL abort_mismatch: got %0d want %0d", mismatch_count, count_diff(e, tx_bits, 10)); end
        n_cmp++; if (first_fail !== first_diff(e, tx_bits, 10)) begin n_fail++; $display("FAIL abort_first_fail: got %0d want %0d", first_fail, first_diff(e, tx_bits, 10)); end
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got done pulse want none"); end
        n_cmp++; if ((int'(match_count) + int'(mismatch_count)) != 10) begin n_fail++; $display("FAIL abort_sum: got %0d want 10", int'(match_count) + int'(mismatch_count)); end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_start_busy_async_rst();
        int cyc;
        start_eval(16'h1234, 0);
        cyc = 1;
        while ((int'(match_count) + int'(mismatch_count)) != 20 && cyc < 200) begin
            start = (cyc == 10);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++; if (cyc != 24) begin n_fail++; $display("FAIL busy_start_timing: got cycle %0d want 24", cyc); end
        n_cmp++; if (match_count !== CW'(20)) begin n_fail++; $display("FAIL busy_start_match: got %0d want 20", match_count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (dut_rst !== 1'b1 || dut_i !== 1'b0) begin n_fail++; $display("FAIL arst_dut: got dut_rst=%b dut_i=%b want 1/0", dut_rst, dut_i); end
        n_cmp++; if (match_count !== '0 || mismatch_count !== '0) begin n_fail++; $display("FAIL arst_counts: got %0d/%0d want 0/0", match_count, mismatch_count); end
        n_cmp++; if (first_fail !== NONE) begin n_fail++; $display("FAIL arst_first_fail: got %0d want %0d", first_fail, NONE); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tie_low();
        test_tie_high();
        test_seed_zero();
        test_back_to_back();
        test_abort();
        test_start_busy_async_rst();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
